// File: rtl/isa_bus_pkg.sv
// Shared types and constants for the ISA bus arbiter: cycle-sequencer states,
// DRQ line index map and the default strobe length.
package isa_bus_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    CMD     = 3'd2,
    HOLD    = 3'd3,
    RECOVER = 3'd4
  } state_e;

  localparam int CH_DRQ1 = 0;
  localparam int CH_DRQ3 = 1;
  localparam int CH_DRQ5 = 2;
  localparam int CH_DRQ7 = 3;

  localparam int CMD_CYCLES_DEF = 3;

endpackage

// File: rtl/drq_sync.sv
// Multi-stage synchroniser bringing the raw asynchronous DRQ lines into the
// system clock domain; synchronous active-high reset clears every stage.
module drq_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_drq,
  output logic [WIDTH-1:0] o_drq_s
);

  logic [WIDTH-1:0] r_sync [STAGES];

  // shift chain: stage 0 samples the raw lines, the last stage feeds the arbiter
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < STAGES; i++) begin
        r_sync[i] <= {WIDTH{1'b0}};
      end
    end else begin
      r_sync[0] <= i_drq;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_drq_s = r_sync[STAGES-1];

endmodule

// File: rtl/isa_bus_arbiter.sv
// Arbitrates the ISA control strobes between port-scan I/O cycles and the DMA
// request lines, then sequences SETUP/CMD/HOLD/RECOVER in bus-clock steps.
module isa_bus_arbiter
  import isa_bus_pkg::*;
#(
  parameter int                 NUM_DRQ      = 4,
  parameter int                 CMD_CYCLES   = CMD_CYCLES_DEF,
  parameter int                 SYNC_STAGES  = 2,
  parameter logic [NUM_DRQ-1:0] DMA_IOR_MASK = 4'b1111
) (
  input  logic                       i_clk_50MHz,
  input  logic                       i_reset,
  input  logic                       i_bus_clk_en,
  input  logic [NUM_DRQ-1:0]         i_drq,
  input  logic                       i_io_req,
  input  logic                       i_io_write,
  output logic                       o_io_gnt,
  output logic                       o_io_ack,
  output logic [NUM_DRQ-1:0]         o_dack_n,
  output logic                       o_aen,
  output logic                       o_ior_n,
  output logic                       o_iow_n,
  output logic [$clog2(NUM_DRQ)-1:0] o_active_ch,
  output logic                       o_busy
);

  localparam int CH_W = $clog2(NUM_DRQ);

  logic [NUM_DRQ-1:0] w_drq_s;
  logic [CH_W-1:0]    w_win_ch;

  state_e          r_state, w_next_state;
  logic [3:0]      r_cnt, w_next_cnt;
  logic [CH_W-1:0] r_ch, w_next_ch;
  logic            r_is_io, w_next_is_io;
  logic            r_io_wr, w_next_io_wr;
  logic            r_last_dma, w_next_last_dma;
  logic            w_io_ack;

  logic [NUM_DRQ-1:0] r_dack_n, w_dack_n;
  logic               r_aen, w_aen;
  logic               r_io_gnt, w_io_gnt;
  logic               r_ior_n, w_ior_n;
  logic               r_iow_n, w_iow_n;
  logic               r_io_ack;
  logic               r_busy;

  drq_sync #(
    .WIDTH  (NUM_DRQ),
    .STAGES (SYNC_STAGES)
  ) u_drq_sync (
    .i_clk   (i_clk_50MHz),
    .i_reset (i_reset),
    .i_drq   (i_drq),
    .o_drq_s (w_drq_s)
  );

  // fixed-priority encoder: lowest set index wins
  always_comb begin
    w_win_ch = {CH_W{1'b0}};
    for (int i = NUM_DRQ - 1; i >= 0; i--) begin
      w_win_ch = w_drq_s[i] ? i[CH_W-1:0] : w_win_ch;
    end
  end

  // next-state, grant latching and fairness update; advances only on bus_clk_en
  always_comb begin
    w_next_state    = r_state;
    w_next_cnt      = r_cnt;
    w_next_ch       = r_ch;
    w_next_is_io    = r_is_io;
    w_next_io_wr    = r_io_wr;
    w_next_last_dma = r_last_dma;
    w_io_ack        = 1'b0;
    if (i_bus_clk_en) begin
      case (r_state)
        IDLE: begin
          // I/O is owed the bus after a DMA transfer, otherwise only when no DRQ is pending
          if (i_io_req && (r_last_dma || (w_drq_s == {NUM_DRQ{1'b0}}))) begin
            w_next_state    = SETUP;
            w_next_is_io    = 1'b1;
            w_next_io_wr    = i_io_write;
            w_next_last_dma = 1'b0;
          end else if (w_drq_s != {NUM_DRQ{1'b0}}) begin
            w_next_state    = SETUP;
            w_next_is_io    = 1'b0;
            w_next_ch       = w_win_ch;
            w_next_last_dma = 1'b1;
          end else begin
            w_next_state = IDLE;
          end
        end
        SETUP: begin
          w_next_state = CMD;
          w_next_cnt   = 4'd0;
        end
        CMD: begin
          if (r_cnt == 4'(CMD_CYCLES - 1)) begin
            w_next_state = HOLD;
          end else begin
            w_next_cnt = r_cnt + 4'd1;
          end
        end
        HOLD:    w_next_state = RECOVER;
        RECOVER: begin
          w_next_state = IDLE;
          w_io_ack     = r_is_io;
        end
        default: w_next_state = IDLE;
      endcase
    end else begin
      w_next_state = r_state;
    end
  end

  // output decode from the state being entered, so the pins register with it
  always_comb begin
    w_dack_n = {NUM_DRQ{1'b1}};
    w_aen    = 1'b0;
    w_io_gnt = 1'b0;
    w_ior_n  = 1'b1;
    w_iow_n  = 1'b1;
    case (w_next_state)
      SETUP, CMD, HOLD: begin
        if (w_next_is_io) begin
          w_io_gnt = 1'b1;
        end else begin
          w_dack_n[w_next_ch] = 1'b0;
          w_aen               = 1'b1;
        end
        if (w_next_state == CMD) begin
          if (w_next_is_io ? !w_next_io_wr : DMA_IOR_MASK[w_next_ch]) begin
            w_ior_n = 1'b0;
          end else begin
            w_iow_n = 1'b0;
          end
        end else begin
          w_ior_n = 1'b1;
        end
      end
      default: w_aen = 1'b0;
    endcase
  end

  // sequencer state and registered pins
  always_ff @(posedge i_clk_50MHz) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_ch       <= CH_DRQ1[CH_W-1:0];
      r_is_io    <= 1'b0;
      r_io_wr    <= 1'b0;
      r_last_dma <= 1'b0;
      r_dack_n   <= {NUM_DRQ{1'b1}};
      r_aen      <= 1'b0;
      r_io_gnt   <= 1'b0;
      r_ior_n    <= 1'b1;
      r_iow_n    <= 1'b1;
      r_io_ack   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_cnt      <= w_next_cnt;
      r_ch       <= w_next_ch;
      r_is_io    <= w_next_is_io;
      r_io_wr    <= w_next_io_wr;
      r_last_dma <= w_next_last_dma;
      r_dack_n   <= w_dack_n;
      r_aen      <= w_aen;
      r_io_gnt   <= w_io_gnt;
      r_ior_n    <= w_ior_n;
      r_iow_n    <= w_iow_n;
      r_io_ack   <= w_io_ack;
      r_busy     <= (w_next_state != IDLE);
    end
  end

  assign o_dack_n    = r_dack_n;
  assign o_aen       = r_aen;
  assign o_io_gnt    = r_io_gnt;
  assign o_ior_n     = r_ior_n;
  assign o_iow_n     = r_iow_n;
  assign o_io_ack    = r_io_ack;
  assign o_busy      = r_busy;
  assign o_active_ch = r_ch;

endmodule

// File: tb/tb_isa_bus_arbiter.sv
// Self-checking bench: directed scenarios with hand-computed expectations plus
// randomized traffic compared every cycle against a transfer-position model.
module tb_isa_bus_arbiter;
  import isa_bus_pkg::*;

  localparam int         NCH  = 4;
  localparam int         CMDC = 3;
  localparam logic [3:0] MASK = 4'b1111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bus_clk_en = 1'b0;
  logic [3:0] drq = 4'd0;
  logic       io_req = 1'b0;
  logic       io_write = 1'b0;
  logic       o_io_gnt, o_io_ack, o_aen, o_ior_n, o_iow_n, o_busy;
  logic [3:0] o_dack_n;
  logic [1:0] o_active_ch;

  int n_checks = 0;
  int n_errors = 0;
  int en_cnt = 0;

  isa_bus_arbiter #(
    .NUM_DRQ(NCH), .CMD_CYCLES(CMDC), .SYNC_STAGES(2), .DMA_IOR_MASK(MASK)
  ) dut (
    .i_clk_50MHz (clk),
    .i_reset     (reset),
    .i_bus_clk_en(bus_clk_en),
    .i_drq       (drq),
    .i_io_req    (io_req),
    .i_io_write  (io_write),
    .o_io_gnt    (o_io_gnt),
    .o_io_ack    (o_io_ack),
    .o_dack_n    (o_dack_n),
    .o_aen       (o_aen),
    .o_ior_n     (o_ior_n),
    .o_iow_n     (o_iow_n),
    .o_active_ch (o_active_ch),
    .o_busy      (o_busy)
  );

  always #10 clk = ~clk;

  // bus clock enable: one pulse every 13 system clocks
  always @(negedge clk) begin
    en_cnt     = (en_cnt == 12) ? 0 : en_cnt + 1;
    bus_clk_en = (en_cnt == 12);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A transfer is a run of CMDC+3 bus clocks: position 0 = setup,
  // 1..CMDC = strobe, CMDC+1 = hold, CMDC+2 = recover.
  logic [3:0] m_sync [2];
  logic [3:0] m_ds;
  bit m_busy, m_io, m_wr, m_last, m_ack, m_valid;
  int m_pos, m_ch;

  always @(posedge clk) begin
    if (reset) begin
      m_sync[0] = 4'd0; m_sync[1] = 4'd0;
      m_busy = 0; m_io = 0; m_wr = 0; m_last = 0; m_ack = 0;
      m_pos = 0; m_ch = 0; m_valid = 1;
    end else begin
      m_ds  = m_sync[1];
      m_ack = 0;
      if (bus_clk_en) begin
        if (!m_busy) begin
          if (io_req && (m_last || m_ds == 4'd0)) begin
            m_busy = 1; m_pos = 0; m_io = 1; m_wr = io_write; m_last = 0;
          end else if (m_ds != 4'd0) begin
            m_busy = 1; m_pos = 0; m_io = 0; m_last = 1;
            for (int i = NCH - 1; i >= 0; i--) if (m_ds[i]) m_ch = i;
          end
        end else if (m_pos == CMDC + 2) begin
          m_busy = 0; m_ack = m_io;
        end else begin
          m_pos++;
        end
      end
      m_sync[1] = m_sync[0];
      m_sync[0] = drq;
    end
  end

  logic [3:0] e_dack;
  bit e_own, e_strobe, e_rd;

  // every-cycle comparison of all outputs against the model plus invariants
  always @(negedge clk) begin
    if (m_valid) begin
      e_own    = m_busy && (m_pos <= CMDC + 1);
      e_strobe = m_busy && (m_pos >= 1) && (m_pos <= CMDC);
      e_rd     = m_io ? !m_wr : MASK[m_ch];
      e_dack   = 4'hF;
      if (e_own && !m_io) e_dack[m_ch] = 1'b0;
      check("dack_n", o_dack_n, e_dack);
      check("aen", o_aen, e_own && !m_io);
      check("io_gnt", o_io_gnt, e_own && m_io);
      check("ior_n", o_ior_n, !(e_strobe && e_rd));
      check("iow_n", o_iow_n, !(e_strobe && !e_rd));
      check("io_ack", o_io_ack, m_ack);
      check("busy", o_busy, m_busy);
      check("active_ch", o_active_ch, m_ch);
      check("inv_one_dack", $countones(~o_dack_n) <= 1, 1);
      check("inv_strobes", !(!o_ior_n && !o_iow_n), 1);
      check("inv_aen_gnt", !(o_aen && o_io_gnt), 1);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_busy(input logic val, input int limit, input string name);
    int n = 0;
    while (o_busy !== val && n < limit) begin tick(); n++; end
    if (o_busy !== val) check(name, o_busy, val);
  endtask

  task automatic reset_dut();
    drq = 4'd0; io_req = 1'b0; io_write = 1'b0;
    reset = 1'b1; tick(); tick(); reset = 1'b0;
  endtask

  int lat, n_busy, n_ior, n_iow, n_dack, n_gnt, n_ack, n_rise;
  bit prev_busy;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    reset_dut();
    check("reset_dack_n", o_dack_n, 4'hF);
    check("reset_busy", o_busy, 0);
    check("reset_strobes", {o_ior_n, o_iow_n}, 2'b11);

    // 1: single DMA on DRQ5
    drq = 4'b0100; lat = 0;
    while (o_busy !== 1'b1 && lat < 40) begin tick(); lat++; end
    check("t1_latency_ok", lat <= 16, 1);
    check("t1_dack", o_dack_n, 4'b1011);
    check("t1_aen", o_aen, 1);
    drq = 4'd0; n_busy = 0; n_ior = 0; n_dack = 0;
    while (o_busy === 1'b1 && n_busy < 200) begin
      n_busy++;
      if (o_ior_n === 1'b0) n_ior++;
      if (o_dack_n !== 4'hF) n_dack++;
      tick();
    end
    check("t1_busy_clks", n_busy, 78);
    check("t1_ior_clks", n_ior, 39);
    check("t1_dack_clks", n_dack, 65);
    repeat (20) tick();
    check("t1_idle_after", o_busy, 0);

    // 2: priority between DRQ3 and DRQ7
    drq = 4'b1010;
    wait_busy(1'b1, 40, "t2_grant1_timeout");
    check("t2_ch_first", o_active_ch, CH_DRQ3);
    check("t2_dack_first", o_dack_n, 4'b1101);
    drq = 4'b1000;
    wait_busy(1'b0, 100, "t2_done1_timeout");
    wait_busy(1'b1, 40, "t2_grant2_timeout");
    check("t2_ch_second", o_active_ch, CH_DRQ7);
    check("t2_dack_second", o_dack_n, 4'b0111);
    drq = 4'd0;
    wait_busy(1'b0, 100, "t2_done2_timeout");

    // 3: fairness between held DRQ1 and I/O writes
    reset_dut();
    drq = 4'b0001; tick(); tick(); tick();
    io_req = 1'b1; io_write = 1'b1;
    for (int g = 0; g < 4; g++) begin
      wait_busy(1'b1, 60, "t3_grant_timeout");
      check("t3_grant_is_io", o_io_gnt, g % 2);
      check("t3_aen", o_aen, (g % 2) == 0);
      wait_busy(1'b0, 100, "t3_done_timeout");
      check("t3_ack", o_io_ack, g % 2);
      tick();
      check("t3_ack_one_clk", o_io_ack, 0);
      if (g % 2 == 1) begin
        io_req = 1'b0;
        if (g == 3) drq = 4'd0;
        tick();
        if (g < 3) io_req = 1'b1;
      end
    end
    repeat (30) tick();
    check("t3_idle_after", o_busy, 0);

    // 4: isolated I/O read
    io_req = 1'b1; io_write = 1'b0;
    wait_busy(1'b1, 40, "t4_grant_timeout");
    check("t4_gnt", o_io_gnt, 1);
    check("t4_aen", o_aen, 0);
    n_gnt = 0; n_ior = 0; n_iow = 0; n_busy = 0;
    while (o_busy === 1'b1 && n_busy < 200) begin
      n_busy++;
      if (o_io_gnt === 1'b1) n_gnt++;
      if (o_ior_n === 1'b0) n_ior++;
      if (o_iow_n === 1'b0) n_iow++;
      tick();
    end
    check("t4_gnt_clks", n_gnt, 65);
    check("t4_ior_clks", n_ior, 39);
    check("t4_iow_clks", n_iow, 0);
    n_ack = (o_io_ack === 1'b1) ? 1 : 0;
    io_req = 1'b0;
    repeat (40) begin tick(); if (o_io_ack === 1'b1) n_ack++; end
    check("t4_ack_count", n_ack, 1);
    check("t4_idle_after", o_busy, 0);

    // 5: reset in the middle of a DMA strobe
    drq = 4'b0100; lat = 0;
    while (o_ior_n !== 1'b0 && lat < 60) begin tick(); lat++; end
    check("t5_in_cmd", o_ior_n, 0);
    drq = 4'd0; tick(); tick(); tick();
    reset = 1'b1; tick();
    check("t5_dack", o_dack_n, 4'hF);
    check("t5_aen", o_aen, 0);
    check("t5_strobes", {o_ior_n, o_iow_n}, 2'b11);
    check("t5_busy", o_busy, 0);
    check("t5_ack", o_io_ack, 0);
    reset = 1'b0;
    drq = 4'b0001;
    wait_busy(1'b1, 40, "t5_regrant_timeout");
    check("t5_regrant_ch", o_active_ch, CH_DRQ1);
    check("t5_regrant_dack", o_dack_n, 4'b1110);
    drq = 4'd0;
    wait_busy(1'b0, 100, "t5_done_timeout");

    // 6: one-clock glitches on DRQ5 at assorted bus-clock phases
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 12)) tick();
      drq = 4'b0100; tick(); drq = 4'd0;
      n_rise = 0; prev_busy = o_busy;
      repeat (120) begin
        tick();
        if (o_busy === 1'b1 && !prev_busy) n_rise++;
        prev_busy = o_busy;
      end
      check("t6_grants_le1", n_rise <= 1, 1);
      check("t6_idle_after", o_busy, 0);
    end

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      tick();
      reset = 1'b0;
      if ($urandom_range(0, 9) == 0) drq = 4'($urandom_range(0, 15));
      if (io_req && m_ack) io_req = 1'b0;
      else if (!io_req && $urandom_range(0, 15) == 0) begin
        io_req = 1'b1; io_write = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 799) == 0) reset = 1'b1;
    end
    tick();
    reset = 1'b0; drq = 4'd0; io_req = 1'b0;
    repeat (200) tick();
    check("end_idle", o_busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
